// File: rtl/icache_victim_ctrl.sv
// Control FSM for an N-way instruction cache backed by a fully-associative victim buffer.
// Drives array write strobes, fill-source select and the memory read request.
module icache_victim_ctrl #(
    parameter int unsigned WAYS         = 2,
    parameter int unsigned VICT_ENTRIES = 4,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       mem_read,
    output logic                       mem_resp,
    input  logic [WAYS-1:0]            hit_way,
    input  logic [WAYS-1:0]            valid,
    input  logic [$clog2(WAYS)-1:0]    repl_way,
    input  logic [VICT_ENTRIES-1:0]    vhit,
    input  logic [VICT_ENTRIES-1:0]    vvalid,
    input  logic                       victim_en,
    input  logic                       cnt_clr,
    output logic                       pmem_read,
    input  logic                       pmem_resp,
    output logic [WAYS-1:0]            ld_tag,
    output logic [WAYS-1:0]            ld_data,
    output logic [WAYS-1:0]            ld_valid,
    output logic                       valid_in,
    output logic [1:0]                 data_sel,
    output logic                       ld_lru,
    output logic [$clog2(WAYS)-1:0]    lru_way,
    output logic [VICT_ENTRIES-1:0]    vld_tag,
    output logic [VICT_ENTRIES-1:0]    vld_data,
    output logic [VICT_ENTRIES-1:0]    vld_valid,
    output logic                       v_valid_in,
    output logic [$clog2(WAYS)-1:0]    v_src_way,
    output logic [CNT_W-1:0]           miss_cnt,
    output logic [CNT_W-1:0]           vhit_cnt,
    output logic                       busy
);

    localparam int unsigned WW = $clog2(WAYS);
    localparam int unsigned VW = (VICT_ENTRIES > 1) ? $clog2(VICT_ENTRIES) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, SWAP, EVICT, FILL} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [VW-1:0]           vptr;
    logic [WW-1:0]           hit_idx;
    logic                    hit_any;
    logic [VW-1:0]           vhit_idx;
    logic                    vhit_any;
    logic [VW-1:0]           free_idx;
    logic                    free_any;
    logic [VW-1:0]           evict_slot;
    logic [WAYS-1:0]         repl_oh;
    logic                    miss_inc;
    logic                    vhit_inc;

    // Lowest-index priority encoders; multi-hot inputs resolve to the lowest set bit.
    always_comb begin
        hit_idx  = '0;
        vhit_idx = '0;
        free_idx = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_way[i]) hit_idx = WW'(i);
        end
        for (int i = VICT_ENTRIES - 1; i >= 0; i--) begin
            if (vhit[i])    vhit_idx = VW'(i);
            if (!vvalid[i]) free_idx = VW'(i);
        end
    end

    assign hit_any    = |hit_way;
    assign vhit_any   = |vhit;
    assign free_any   = ~&vvalid;
    assign evict_slot = free_any ? free_idx : vptr;
    assign repl_oh    = WAYS'(1) << repl_way;

    always_comb begin
        state_next = state;
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        ld_tag     = '0;
        ld_data    = '0;
        ld_valid   = '0;
        valid_in   = 1'b0;
        data_sel   = 2'b00;
        ld_lru     = 1'b0;
        lru_way    = '0;
        vld_tag    = '0;
        vld_data   = '0;
        vld_valid  = '0;
        v_valid_in = 1'b0;
        v_src_way  = '0;
        miss_inc   = 1'b0;
        vhit_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_read) state_next = LOOKUP;
            end
            LOOKUP: begin
                if (!mem_read) begin
                    state_next = IDLE;
                end else if (hit_any) begin
                    mem_resp = 1'b1;
                    ld_lru   = 1'b1;
                    lru_way  = hit_idx;
                end else if (victim_en && vhit_any) begin
                    state_next = SWAP;
                end else if (victim_en && valid[repl_way]) begin
                    state_next = EVICT;
                end else begin
                    state_next = FILL;
                end
            end
            SWAP: begin
                // Cache line and victim entry exchange places in a single cycle.
                if (vhit_any) begin
                    vld_tag   = VICT_ENTRIES'(1) << vhit_idx;
                    vld_data  = VICT_ENTRIES'(1) << vhit_idx;
                    vld_valid = VICT_ENTRIES'(1) << vhit_idx;
                end
                v_valid_in = valid[repl_way];
                v_src_way  = repl_way;
                ld_tag     = repl_oh;
                ld_data    = repl_oh;
                ld_valid   = repl_oh;
                valid_in   = 1'b1;
                data_sel   = 2'b10;
                vhit_inc   = 1'b1;
                state_next = LOOKUP;
            end
            EVICT: begin
                vld_tag    = VICT_ENTRIES'(1) << evict_slot;
                vld_data   = VICT_ENTRIES'(1) << evict_slot;
                vld_valid  = VICT_ENTRIES'(1) << evict_slot;
                v_valid_in = 1'b1;
                v_src_way  = repl_way;
                state_next = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    ld_tag     = repl_oh;
                    ld_data    = repl_oh;
                    ld_valid   = repl_oh;
                    valid_in   = 1'b1;
                    data_sel   = 2'b01;
                    miss_inc   = 1'b1;
                    state_next = LOOKUP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SWAP) || (state == EVICT) || (state == FILL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vptr     <= '0;
            miss_cnt <= '0;
            vhit_cnt <= '0;
        end else begin
            state <= state_next;
            // Round-robin pointer moves only when every victim entry was occupied.
            if (state == EVICT && !free_any) begin
                if (vptr == VW'(VICT_ENTRIES - 1)) vptr <= '0;
                else                               vptr <= vptr + VW'(1);
            end
            if (cnt_clr)                          miss_cnt <= '0;
            else if (miss_inc && miss_cnt != '1)  miss_cnt <= miss_cnt + CNT_W'(1);
            if (cnt_clr)                          vhit_cnt <= '0;
            else if (vhit_inc && vhit_cnt != '1)  vhit_cnt <= vhit_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_icache_victim_ctrl.sv
// Directed plus randomized bench for icache_victim_ctrl against a transaction-level model.
module tb_icache_victim_ctrl;

    localparam int WAYS = 4;
    localparam int VE   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_resp;
    logic [3:0]    hit_way, valid;
    logic [1:0]    repl_way;
    logic [3:0]    vhit, vvalid;
    logic          victim_en, cnt_clr, pmem_read, pmem_resp;
    logic [3:0]    ld_tag, ld_data, ld_valid;
    logic          valid_in;
    logic [1:0]    data_sel;
    logic          ld_lru;
    logic [1:0]    lru_way;
    logic [3:0]    vld_tag, vld_data, vld_valid;
    logic          v_valid_in;
    logic [1:0]    v_src_way;
    logic [CW-1:0] miss_cnt, vhit_cnt;
    logic          busy;

    icache_victim_ctrl #(.WAYS(WAYS), .VICT_ENTRIES(VE), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_resp(mem_resp),
        .hit_way(hit_way), .valid(valid), .repl_way(repl_way), .vhit(vhit),
        .vvalid(vvalid), .victim_en(victim_en), .cnt_clr(cnt_clr),
        .pmem_read(pmem_read), .pmem_resp(pmem_resp), .ld_tag(ld_tag),
        .ld_data(ld_data), .ld_valid(ld_valid), .valid_in(valid_in),
        .data_sel(data_sel), .ld_lru(ld_lru), .lru_way(lru_way), .vld_tag(vld_tag),
        .vld_data(vld_data), .vld_valid(vld_valid), .v_valid_in(v_valid_in),
        .v_src_way(v_src_way), .miss_cnt(miss_cnt), .vhit_cnt(vhit_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: where the request is, victim pointer, counters.
    string where, nxt;
    int    vptr_m, miss_m, vhit_m;
    logic  inc_miss, inc_vhit, adv_vptr;
    logic       e_resp, e_pread, e_vin, e_lru, e_vvin, e_busy;
    logic [3:0] e_ld, e_vld;
    logic [1:0] e_dsel, e_lway, e_vsrc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        where = "idle"; vptr_m = 0; miss_m = 0; vhit_m = 0;
    endtask

    task automatic model_eval();
        int h, vh, fr, slot;
        if (!rst_n) model_reset();
        {e_resp, e_pread, e_vin, e_lru, e_vvin} = '0;
        e_ld = '0; e_vld = '0; e_dsel = '0; e_lway = '0; e_vsrc = '0;
        inc_miss = 0; inc_vhit = 0; adv_vptr = 0; nxt = where;
        h  = lowest(32'(hit_way), WAYS);
        vh = lowest(32'(vhit), VE);
        if (where == "idle") begin
            if (mem_read) nxt = "lookup";
        end else if (where == "lookup") begin
            if (!mem_read) nxt = "idle";
            else if (h >= 0) begin e_resp = 1; e_lru = 1; e_lway = 2'(h); end
            else if (victim_en && vh >= 0) nxt = "swap";
            else if (victim_en && valid[repl_way]) nxt = "evict";
            else nxt = "fill";
        end else if (where == "swap") begin
            if (vh >= 0) e_vld[vh] = 1'b1;
            e_vvin = valid[repl_way]; e_vsrc = repl_way;
            e_ld[repl_way] = 1'b1; e_vin = 1; e_dsel = 2'b10;
            inc_vhit = 1; nxt = "lookup";
        end else if (where == "evict") begin
            fr = lowest(32'(~vvalid), VE);
            slot = (fr >= 0) ? fr : vptr_m;
            adv_vptr = (fr < 0);
            e_vld[slot] = 1'b1; e_vvin = 1; e_vsrc = repl_way; nxt = "fill";
        end else begin
            e_pread = 1;
            if (pmem_resp) begin
                e_ld[repl_way] = 1'b1; e_vin = 1; e_dsel = 2'b01;
                inc_miss = 1; nxt = "lookup";
            end
        end
        e_busy = (where == "swap") || (where == "evict") || (where == "fill");
    endtask

    task automatic model_update();
        if (!rst_n) begin
            model_reset();
            return;
        end
        where = nxt;
        if (adv_vptr) vptr_m = (vptr_m + 1) % VE;
        if (cnt_clr) begin miss_m = 0; vhit_m = 0; end
        else begin
            if (inc_miss && miss_m < CMAX) miss_m++;
            if (inc_vhit && vhit_m < CMAX) vhit_m++;
        end
    endtask

    task automatic check_cycle();
        #1;
        model_eval();
        chk("mem_resp", mem_resp, e_resp);
        chk("pmem_read", pmem_read, e_pread);
        chk("ld_tag", ld_tag, e_ld);
        chk("ld_data", ld_data, e_ld);
        chk("ld_valid", ld_valid, e_ld);
        chk("valid_in", valid_in, e_vin);
        chk("data_sel", data_sel, e_dsel);
        chk("ld_lru", ld_lru, e_lru);
        chk("lru_way", lru_way, e_lway);
        chk("vld_tag", vld_tag, e_vld);
        chk("vld_data", vld_data, e_vld);
        chk("vld_valid", vld_valid, e_vld);
        chk("v_valid_in", v_valid_in, e_vvin);
        chk("v_src_way", v_src_way, e_vsrc);
        chk("miss_cnt", miss_cnt, miss_m);
        chk("vhit_cnt", vhit_cnt, vhit_m);
        chk("busy", busy, e_busy);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic quiet_inputs();
        mem_read = 0; hit_way = 0; valid = 0; repl_way = 0; vhit = 0; vvalid = 0;
        victim_en = 1; cnt_clr = 0; pmem_resp = 0;
    endtask

    initial begin
        model_reset();
        rst_n = 0;
        quiet_inputs();
        @(negedge clk);
        check_cycle();
        chk("rst_miss_cnt", miss_cnt, 0);
        chk("rst_busy", busy, 0);
        tick();
        rst_n = 1;

        // Hits: response one cycle after request, then every cycle.
        mem_read = 1; hit_way = 4'b0010; valid = 4'b1111;
        check_cycle(); chk("idle_no_resp", mem_resp, 0); tick();
        check_cycle(); chk("hit_resp", mem_resp, 1); chk("hit_lru_way", lru_way, 1); tick();
        check_cycle(); chk("b2b_resp", mem_resp, 1); tick();
        hit_way = 4'b0110;
        check_cycle(); chk("multihot_lru_way", lru_way, 1); tick();

        // Plain fill from memory, response after five cycles.
        hit_way = 0; valid = 0; repl_way = 0;
        check_cycle(); tick();
        for (int k = 0; k < 5; k++) begin
            pmem_resp = (k == 4);
            check_cycle();
            chk("fill_pmem_read", pmem_read, 1);
            if (k == 4) begin
                chk("fill_ld_valid", ld_valid, 4'b0001);
                chk("fill_data_sel", data_sel, 2'b01);
            end
            tick();
        end
        pmem_resp = 0; hit_way = 4'b0001;
        check_cycle(); chk("fill_miss_cnt", miss_cnt, 1); chk("fill_then_resp", mem_resp, 1);
        tick();

        // Evictions into a full victim buffer walk round-robin, then a free slot wins.
        hit_way = 0; valid = 4'b1111; vvalid = 4'b1111; repl_way = 2;
        for (int i = 0; i < 7; i++) begin
            if (i == 5) vvalid = 4'b1011;
            if (i == 6) vvalid = 4'b1111;
            check_cycle(); tick();
            check_cycle();
            chk("evict_slot", vld_tag, (i == 5) ? 4'b0100 : (4'b0001 << ((i == 6) ? 1 : i % 4)));
            chk("evict_vvin", v_valid_in, 1);
            tick();
            pmem_resp = 1; check_cycle(); tick(); pmem_resp = 0;
        end

        // Victim hit: LOOKUP, SWAP, LOOKUP-hit.
        vhit = 4'b0100; repl_way = 3; valid = 4'b1000;
        check_cycle(); chk("swap_lookup_noresp", mem_resp, 0); tick();
        check_cycle();
        chk("swap_vld", vld_tag, 4'b0100); chk("swap_ld", ld_tag, 4'b1000);
        chk("swap_dsel", data_sel, 2'b10); chk("swap_vvin", v_valid_in, 1);
        tick();
        hit_way = 4'b1000; vhit = 0;
        check_cycle(); chk("swap_resp", mem_resp, 1); chk("swap_vhit_cnt", vhit_cnt, 1); tick();

        // Bypass: victim hit ignored, straight to FILL.
        victim_en = 0; vhit = 4'b0001; valid = 4'b1111; repl_way = 2; hit_way = 0;
        check_cycle(); tick();
        check_cycle(); chk("bypass_fill", pmem_read, 1); chk("bypass_vld", vld_tag, 0); tick();

        // Reset in the middle of a fill.
        check_cycle(); tick();
        #2 rst_n = 0;
        check_cycle();
        chk("rst_mid_pread", pmem_read, 0); chk("rst_mid_cnt", miss_cnt, 0);
        tick();
        rst_n = 1; mem_read = 0; pmem_resp = 1;
        check_cycle(); tick();
        check_cycle(); chk("stray_resp_cnt", miss_cnt, 0); chk("stray_busy", busy, 0); tick();

        // Clear coinciding with a fill completion.
        mem_read = 1; pmem_resp = 0;
        check_cycle(); tick();
        check_cycle(); tick();
        pmem_resp = 1; cnt_clr = 1;
        check_cycle(); tick();
        cnt_clr = 0; pmem_resp = 0; mem_read = 0;
        check_cycle(); chk("clr_priority", miss_cnt, 0); tick();

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            int r;
            rst_n     = ($urandom_range(0, 199) != 0);
            mem_read  = ($urandom_range(0, 99) < 85);
            r = $urandom_range(0, 3);
            hit_way   = (r < 2) ? 4'b0 : (r == 2) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            r = $urandom_range(0, 3);
            vhit      = (r < 2) ? 4'b0 : (r == 2) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom);
            valid     = 4'($urandom);
            vvalid    = ($urandom_range(0, 1) == 1) ? 4'b1111 : 4'($urandom);
            repl_way  = 2'($urandom);
            victim_en = ($urandom_range(0, 99) < 80);
            cnt_clr   = ($urandom_range(0, 99) < 3);
            pmem_resp = ($urandom_range(0, 99) < 35);
            check_cycle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_victim_ctrl.md
Name: icache_victim_ctrl

Overview:
- Parametrised control FSM for an N-way set-associative instruction cache with a fully-associative victim buffer of configurable depth.
- Sits between the fetch stage and the cache arrays and victim arrays; datapath, tag compare and PLRU storage live outside.
- Generates one-hot load strobes, datapath selects and the physical-memory read request.
- Adds over the previous generation: arbitrary way count, multi-entry victim buffer with free-slot/round-robin allocation, runtime victim bypass, saturating performance counters with clear.

Parameters:
WAYS, 2, cache associativity; power of 2, >=2
VICT_ENTRIES, 4, victim buffer entries, >=1
CNT_W, 32, width of miss and victim-hit counters

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
mem_read  input  1  fetch request from CPU
mem_resp  output  1  fetch data valid to CPU
hit_way  input  WAYS  one-hot tag match per way (already qualified by valid)
valid  input  WAYS  valid bits of indexed set
repl_way  input  $clog2(WAYS)  PLRU victim way for indexed set
vhit  input  VICT_ENTRIES  one-hot victim buffer match (qualified by valid)
vvalid  input  VICT_ENTRIES  victim entry valid bits
victim_en  input  1  1 = victim buffer in use, 0 = bypass
cnt_clr  input  1  synchronous clear of both counters
pmem_read  output  1  cacheline read request to memory
pmem_resp  input  1  cacheline returned
ld_tag, ld_data, ld_valid  output  WAYS each  one-hot cache array write strobes
valid_in  output  1  value written on ld_valid
data_sel  output  2  cache fill source: 00 none, 01 pmem, 10 victim
ld_lru  output  1  PLRU update strobe
lru_way  output  $clog2(WAYS)  way to mark MRU
vld_tag, vld_data, vld_valid  output  VICT_ENTRIES each  one-hot victim write strobes
v_valid_in  output  1  value written on vld_valid
v_src_way  output  $clog2(WAYS)  cache way routed into victim write port (= repl_way)
miss_cnt  output  CNT_W  pmem fills completed
vhit_cnt  output  CNT_W  victim swaps completed
busy  output  1  state not in IDLE or LOOKUP

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; counters=0; round-robin pointer vptr=0.
  - All outputs 0.
  - Reset mid-fill abandons the fill; a late pmem_resp in IDLE is ignored.
- Outputs are combinational from state and inputs. All outputs default to 0 in every state.
- IDLE: mem_read=1 -> LOOKUP. No output activity.
- LOOKUP:
  - Hit (|hit_way): mem_resp=1 and ld_lru=1 in the same cycle; lru_way=encode(hit_way). Remain in LOOKUP if mem_read=1 (one hit per cycle), else go to IDLE.
  - Miss, victim_en=1 and |vhit -> SWAP.
  - Miss with victim_en=1 and valid[repl_way]=1 -> EVICT.
  - Other misses -> FILL.
  - mem_read=0 -> IDLE regardless of hit/miss.
- SWAP (exactly 1 cycle):
  - Victim entry encode(vhit) receives cache line repl_way: vld_tag/vld_data/vld_valid set; v_valid_in=valid[repl_way].
  - Cache way repl_way receives the victim line: ld_tag/ld_data/ld_valid one-hot at repl_way; valid_in=1; data_sel=10.
  - vhit_cnt+1. Next state LOOKUP; the hit is then served there.
- EVICT (exactly 1 cycle):
  - Victim slot = lowest-index entry with vvalid=0. If all entries are valid, slot=vptr and vptr advances modulo VICT_ENTRIES.
  - vptr is unchanged when a free slot is used.
  - vld_* strobes asserted at the slot; v_valid_in=1. Next state FILL.
- FILL:
  - pmem_read=1 every cycle until and including the pmem_resp cycle.
  - On pmem_resp: ld_tag/ld_data/ld_valid at repl_way; valid_in=1; data_sel=01; miss_cnt+1; next state LOOKUP.
  - mem_read dropping during FILL does not abort; the fill completes, then LOOKUP goes to IDLE.
- Counters:
  - Saturate at 2^CNT_W-1.
  - cnt_clr has priority over increment in the same cycle.
- Minimum miss latency: request cycle + LOOKUP + (EVICT) + FILL cycles + LOOKUP hit cycle.
- Victim-hit latency: exactly 3 cycles from LOOKUP entry to mem_resp (LOOKUP, SWAP, LOOKUP).
- Priority and illegal inputs:
  - Cache hit beats victim hit when both are set.
  - Multi-hot hit_way or vhit is illegal; the lowest set index is used.
- victim_en=0: SWAP and EVICT are never entered; vld_* stay 0.

Test Plan:
- Reset, mem_read=1, hit_way=2'b10 -> mem_resp=1 one cycle after request; ld_lru=1, lru_way=1; back-to-back hits give mem_resp every cycle.
- Miss with valid=2'b00, repl_way=0: pmem_resp asserted after 5 cycles -> pmem_read high 5 cycles; ld_valid=01, data_sel=01 in resp cycle; miss_cnt=1; next cycle mem_resp=1.
- WAYS=4, VICT_ENTRIES=4, all vvalid=1, 5 evictions -> victim slots 0,1,2,3,0; vptr wraps; no SWAP.
- Miss with vhit=4'b0100, repl_way=3, valid[3]=1 -> SWAP: vld_*=0100, ld_*=1000, data_sel=10; vhit_cnt=1; mem_resp at cycle 3.
- victim_en=0 with vhit=0001 and valid line at repl_way -> goes straight to FILL; vld_* never asserted.
- rst_n pulsed low during FILL -> immediate IDLE, pmem_read=0, counters=0; stray pmem_resp ignored. cnt_clr together with pmem_resp -> miss_cnt=0.
